exu_div: RTL and testbench

EXU_DIV -- requirements
Module: exu_div

---
 rtl/exu_div_pkg.sv | 15 +
 rtl/exu_div_step.sv | 26 ++
 rtl/exu_div.sv | 131 +++++++++++++
 tb/tb_exu_div.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_div_pkg.sv
// Shared types and constants for the iterative integer divider.
package exu_div_pkg;

    localparam int DIV_XLEN     = 64;
    localparam int DIV_WLEN     = 32;
    localparam int SGN_DIVIDEND = 1;
    localparam int SGN_DIVISOR  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/exu_div_step.sv
// One unsigned restoring-division step: shift in the next dividend bit, trial subtract, restore.
module div_step
    import exu_div_pkg::*;
#(
    parameter int DATA_W = DIV_XLEN
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            fits;

    // shifted < 2*divisor, so the extra top bit of diff is a clean borrow flag
    assign shifted = {rem_in, quo_in[DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = ~diff[DATA_W];

    assign rem_out = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_out = {quo_in[DATA_W-2:0], fits};

endmodule

// File: rtl/exu_div.sv
// Multi-cycle RV64 integer divider (DIV/DIVU/REM/REMU and W forms), one quotient bit per clock.
module exu_div
    import exu_div_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [1:0]          in_signed,
    input  logic                in_quotient,
    input  logic                in_word,
    input  logic [DIV_XLEN-1:0] in_dividend,
    input  logic [DIV_XLEN-1:0] in_divisor,
    input  logic                flush,
    output logic                out_idle,
    output logic                out_valid,
    output logic [DIV_XLEN-1:0] out_result
);

    function automatic logic [DIV_XLEN-1:0] negate_if(input logic en, input logic [DIV_XLEN-1:0] v);
        return en ? (~v + {{(DIV_XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [DIV_XLEN-1:0] sext_word(input logic word, input logic [DIV_XLEN-1:0] v);
        return word ? {{(DIV_XLEN-DIV_WLEN){v[DIV_WLEN-1]}}, v[DIV_WLEN-1:0]} : v;
    endfunction

    div_state_e state, state_next;

    logic [6:0]                count;
    logic [DIV_XLEN-1:0]       rem_r, quo_r, dvs_r;
    logic                      neg_quo_r, neg_rem_r, word_r, sel_quo_r;

    logic signed [DIV_XLEN-1:0] dvd_ext, dvs_ext;
    logic [DIV_XLEN-1:0]       dvd_mag, dvs_mag;
    logic [DIV_XLEN-1:0]       fast_res, final_res;
    logic [DIV_XLEN-1:0]       step_rem, step_quo;
    logic                      dvd_neg, dvs_neg, div_zero, sign_ovf, fast, start, last_step;

    // Operand conditioning at the acceptance edge
    always_comb begin
        dvd_ext = in_dividend;
        dvs_ext = in_divisor;
        if (in_word) begin
            dvd_ext = {{(DIV_XLEN-DIV_WLEN){in_signed[SGN_DIVIDEND] & in_dividend[DIV_WLEN-1]}},
                       in_dividend[DIV_WLEN-1:0]};
            dvs_ext = {{(DIV_XLEN-DIV_WLEN){in_signed[SGN_DIVISOR] & in_divisor[DIV_WLEN-1]}},
                       in_divisor[DIV_WLEN-1:0]};
        end
    end

    assign dvd_neg  = in_signed[SGN_DIVIDEND] & dvd_ext[DIV_XLEN-1];
    assign dvs_neg  = in_signed[SGN_DIVISOR]  & dvs_ext[DIV_XLEN-1];
    assign dvd_mag  = negate_if(dvd_neg, dvd_ext);
    assign dvs_mag  = negate_if(dvs_neg, dvs_ext);
    assign div_zero = (dvs_ext == '0);
    assign sign_ovf = (&in_signed) && (dvs_ext == '1) &&
                      (dvd_ext == (in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign fast     = div_zero | sign_ovf;
    assign fast_res = sext_word(in_word, in_quotient ? (div_zero ? '1 : dvd_ext)
                                                     : (div_zero ? dvd_ext : '0));
    assign start    = (state == IDLE) && in_valid && !flush;

    div_step #(.DATA_W(DIV_XLEN)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .divisor (dvs_r),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign last_step = (count == 7'd1);
    assign final_res = sext_word(word_r, sel_quo_r ? negate_if(neg_quo_r, step_quo)
                                                   : negate_if(neg_rem_r, step_rem));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = fast ? DONE : CALC;
            CALC:    if (flush) state_next = IDLE;
                     else if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign out_idle  = (state == IDLE);
    assign out_valid = (state == DONE) && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            dvs_r      <= '0;
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            word_r     <= 1'b0;
            sel_quo_r  <= 1'b0;
            out_result <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                word_r    <= in_word;
                sel_quo_r <= in_quotient;
                neg_quo_r <= dvd_neg ^ dvs_neg;
                neg_rem_r <= dvd_neg;
                rem_r     <= '0;
                // W-ops start with the 32-bit magnitude at the top so the step sees its MSB first
                quo_r     <= in_word ? {dvd_mag[DIV_WLEN-1:0], {DIV_WLEN{1'b0}}} : dvd_mag;
                dvs_r     <= dvs_mag;
                if (fast) begin
                    count      <= '0;
                    out_result <= fast_res;
                end else begin
                    count <= in_word ? 7'd32 : 7'd64;
                end
            end else if (state == CALC) begin
                if (flush) begin
                    count <= '0;
                end else begin
                    rem_r <= step_rem;
                    quo_r <= step_quo;
                    count <= count - 7'd1;
                    if (last_step) out_result <= final_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_exu_div.sv
// Scoreboard bench for exu_div: expected results queued at acceptance, checked when out_valid fires.
module tb_exu_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_signed;
    logic        in_quotient;
    logic        in_word;
    logic [63:0] in_dividend;
    logic [63:0] in_divisor;
    logic        flush;
    logic        out_idle;
    logic        out_valid;
    logic [63:0] out_result;

    exu_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_signed   (in_signed),
        .in_quotient (in_quotient),
        .in_word     (in_word),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .flush       (flush),
        .out_idle    (out_idle),
        .out_valid   (out_valid),
        .out_result  (out_result)
    );

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   prev_valid = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_div(input bit s, input bit q, input bit w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) r32 = q ? 32'hFFFF_FFFF : a32;
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = q ? a32 : 32'd0;
            else if (s) r32 = q ? $signed(a32) / $signed(b32) : $signed(a32) % $signed(b32);
            else r32 = q ? a32 / b32 : a32 % b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0) r64 = q ? '1 : a;
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) r64 = q ? a : 64'd0;
        else if (s) r64 = q ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
        else r64 = q ? a / b : a % b;
        return r64;
    endfunction

    function automatic int ref_lat(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            if (b[31:0] == 32'd0) return 0;
            if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 0;
            return 32;
        end
        if (b == 64'd0) return 0;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 0;
        return 64;
    endfunction

    // Result monitor: pops the scoreboard on every strobe
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (out_valid === 1'b1) begin
                    n_checks++;
                    if (prev_valid) begin
                        n_errors++;
                        $display("FAIL valid_twice: out_valid high two cycles in a row at cycle %0d", cyc);
                    end
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_valid: result %h with nothing pending", out_result);
                    end else begin
                        e = sb.pop_front();
                        n_checks++;
                        if (out_result !== e.res) begin
                            n_errors++;
                            $display("FAIL result: got %h expected %h", out_result, e.res);
                        end
                        if (cyc !== e.cyc) begin
                            n_errors++;
                            $display("FAIL latency: strobe at cycle %0d expected %0d", cyc, e.cyc);
                        end
                    end
                end
                prev_valid = (out_valid === 1'b1);
            end else begin
                prev_valid = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_op(input logic [1:0] sg, input bit q, input bit w, input logic [63:0] a,
                         input logic [63:0] b, input int lat, input logic [63:0] exp_res, input bit push);
        exp_t e;
        for (int i = 0; i < 300 && out_idle !== 1'b1; i++) @(negedge clk);
        if (out_idle !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: out_idle=%b expected 1", out_idle);
        end
        in_valid    = 1'b1;
        in_signed   = sg;
        in_quotient = q;
        in_word     = w;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = exp_res;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: %0d results still pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_signed = 2'b00; in_quotient = 1'b0; in_word = 1'b0;
        in_dividend = '0; in_divisor = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_idle !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_state: idle=%b valid=%b result=%h expected 1 0 0", out_idle, out_valid, out_result);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int busy_bad = 0;
        do_op(2'b00, 1, 0, 64'd100, 64'd7, 64, 64'd14, 1);
        for (int k = 0; k < 64; k++) begin
            if (out_idle !== 1'b0) busy_bad++;
            @(negedge clk);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_errors++;
            $display("FAIL busy_idle: out_idle high in %0d busy cycles, expected 0", busy_bad);
        end
        wait_done();
        do_op(2'b00, 0, 0, 64'd100, 64'd7, 64, 64'd2, 1);
        wait_done();
    endtask

    task automatic test_signed();
        do_op(2'b11, 1, 0, -64'sd7, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        do_op(2'b11, 0, 0, -64'sd7, 64'd2, 64, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_done();
    endtask

    task automatic test_div_zero();
        do_op(2'b00, 1, 0, 64'd5, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op(2'b00, 0, 0, 64'd5, 64'd0, 0, 64'd5, 1);
        wait_done();
    endtask

    task automatic test_overflow();
        do_op(2'b11, 1, 0, 64'h8000_0000_0000_0000, '1, 0, 64'h8000_0000_0000_0000, 1);
        do_op(2'b11, 0, 0, 64'h8000_0000_0000_0000, '1, 0, 64'd0, 1);
        do_op(2'b11, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 64'hFFFF_FFFF_8000_0000, 1);
        wait_done();
    endtask

    task automatic test_word();
        do_op(2'b00, 1, 1, 64'h0000_0000_FFFF_FFFF, 64'd2, 32, 64'h0000_0000_7FFF_FFFF, 1);
        do_op(2'b00, 1, 1, 64'h0000_0000_FFFF_FFFE, 64'd1, 32, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        wait_done();
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        in_valid = 1'b1; in_signed = 2'b00; in_quotient = 1'b1; in_word = 1'b0;
        in_dividend = 64'd50; in_divisor = 64'd5; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        n_checks++;
        if (out_idle !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_idle_accept: out_idle=%b expected 1", out_idle);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_flush();
        logic [63:0] held;
        held = out_result;
        do_op(2'b00, 1, 0, 64'd100, 64'd7, 64, 64'd0, 0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (out_idle !== 1'b1 || out_valid !== 1'b0 || out_result !== held) begin
            n_errors++;
            $display("FAIL flush_calc: idle=%b valid=%b result=%h expected 1 0 %h", out_idle, out_valid, out_result, held);
        end
        do_op(2'b00, 1, 0, 64'd9, 64'd3, 64, 64'd3, 1);
        wait_done();
    endtask

    task automatic test_reset_mid();
        do_op(2'b00, 1, 0, 64'd1000, 64'd3, 64, 64'd0, 0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_idle !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_mid: idle=%b valid=%b result=%h expected 1 0 0", out_idle, out_valid, out_result);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(2'b00, 0, 0, 64'd20, 64'd6, 64, 64'd2, 1);
        wait_done();
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b;
        bit s, q, w;
        for (int i = 0; i < 16; i++) begin
            s = $urandom_range(0, 1);
            q = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'($urandom_range(1, 20));
                1:       b = {$urandom, $urandom};
                2:       b = -64'($urandom_range(1, 20));
                default: b = {32'd0, $urandom};
            endcase
            do_op({s, s}, q, w, a, b, ref_lat(s, w, a, b), ref_div(s, q, w, a, b), 1);
        end
        wait_done();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_word();
        test_flush_idle();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
